memory_interface: RTL and testbench
===================================

Name: memory_interface

Overview:
- Sequential bridge between the datapath and the synchronous data memory.
- Takes read and write strobes from control, with the address on the datapath A bus and store data on the B bus.
- Runs a fixed-wait-state memory access.
- Returns read data, registered and held, to the datapath memory-data input, plus a one-cycle completion pulse back to control.

Parameters:
- DATAWIDTH_BUS, 32, width of the data and address buses.
- DATAWIDTH_MEMADDR, 12, word-address width on the memory side.
- WAIT_STATES, 2, extra memory cycles per access; legal range 0..15.

Ports:
- MEMIF_CLOCK_50  input  1  system clock; all logic on the rising edge.
- MEMIF_ResetInHigh_In  input  1  synchronous, active-high reset.
- MEMIF_Read_In  input  1  read request from control.
- MEMIF_Write_In  input  1  write request from control.
- MEMIF_Address_InBUS  input  DATAWIDTH_BUS  byte address from datapath A bus.
- MEMIF_WriteData_InBUS  input  DATAWIDTH_BUS  store data from datapath B bus.
- MEMIF_MemReadData_InBUS  input  DATAWIDTH_BUS  data returned by memory.
- MEMIF_MemoryData_OutBUS  output  DATAWIDTH_BUS  read data to datapath memory-data input.
- MEMIF_Done_Out  output  1  one-cycle completion pulse.
- MEMIF_Busy_Out  output  1  access in progress.
- MEMIF_AlignError_Out  output  1  sticky misaligned-access flag.
- MEMIF_MemAddress_OutBUS  output  DATAWIDTH_MEMADDR  word address to memory.
- MEMIF_MemRead_Out  output  1  memory read enable.
- MEMIF_MemWrite_Out  output  1  memory write enable.
- MEMIF_MemWriteData_OutBUS  output  DATAWIDTH_BUS  write data to memory.

Behaviour:
- Clock and reset: one clock, MEMIF_CLOCK_50. Reset MEMIF_ResetInHigh_In is synchronous and active-high.
- Reset values: state IDLE; every output 0, including the data register, address latch, wait counter and AlignError.
- States: IDLE, ACCESS, DONE.
- IDLE, request sampled:
  - A request is Read_In or Write_In sampled high at an edge.
  - On that edge, latch address bits [DATAWIDTH_MEMADDR+1:2] and the write data.
  - Record the operation, load the counter with WAIT_STATES, and go to ACCESS.
  - Read_In and Write_In both high: perform the write and ignore the read.
- ACCESS:
  - Busy=1.
  - MemRead or MemWrite (per the latched operation) held high for every ACCESS cycle.
  - MemAddress and MemWriteData are driven from the latches and are stable for the whole access.
  - Edge with counter≠0: decrement the counter.
  - Edge with counter=0: on a read, capture MemReadData into the data register; then go to DONE.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle, then IDLE.
  - Done rises WAIT_STATES+1 cycles after the request edge.
- Outside ACCESS: MemRead and MemWrite are 0, and MemAddress and MemWriteData hold their last latched values.
- Requests while Busy: ignored, not queued.
- Request held high across DONE: it is a new request only if still high at the edge that enters IDLE. It is sampled on the first IDLE edge, so back-to-back accesses are possible with one IDLE cycle between them.
- Read data register: MemoryData_OutBUS changes only on read completion. It holds through writes and idle periods.
- Address out of range: high address bits above the word field are silently dropped (wrap-around modulo 2^DATAWIDTH_MEMADDR words).
- Reset mid-operation: abort immediately; no Done pulse; memory enables drop the cycle after the reset edge; the data register is cleared.

Optional Feature:
- Macro: MEMIF_ALIGN_CHECK_EN.
- Defined:
  - A request with Address[1:0]≠0 performs no memory access (MemRead and MemWrite stay 0).
  - It sets AlignError, cleared only by reset.
  - It goes IDLE→DONE directly: Done is high the cycle after the request edge, and the data register is unchanged.
- Not defined:
  - Address[1:0] are ignored and every request accesses the word.
  - AlignError is tied to 0.

Test Plan:
- Reset, then read (WAIT_STATES=2): Read_In=1 for one cycle, Address=0x0000_0010, memory returns 0xDEAD_BEEF → MemAddress=0x004; MemRead high for 3 cycles; Done pulses 3 cycles after the request edge; MemoryData_OutBUS=0xDEAD_BEEF and held afterwards.
- Write: Address=0x0000_0008, WriteData=0x1234_5678 → MemWrite high for 3 cycles with MemAddress=0x002 and MemWriteData=0x1234_5678; MemoryData_OutBUS unchanged; one Done pulse.
- Simultaneous and busy requests: Read_In=Write_In=1 → write only. A second Read_In pulse during ACCESS → ignored; exactly one Done.
- Wrap: read Address=0x0000_4004 (DATAWIDTH_MEMADDR=12) → MemAddress=0x001.
- Reset asserted during the second ACCESS cycle → next cycle: IDLE, all outputs 0, no Done pulse.
- With MEMIF_ALIGN_CHECK_EN, read Address=0x0000_0006 → no MemRead; Done the next cycle; AlignError=1 and stays 1 through a later aligned read until reset.

Source files
------------

// File: rtl/memory_interface.sv
// memory_interface: sequential bridge between the datapath and a synchronous
// data memory. Each read/write request runs a fixed-length access of
// WAIT_STATES+1 memory cycles, then signals completion with a one-cycle Done.
// Read data is registered and held until the next read completes.
// Optional build macro: MEMIF_ALIGN_CHECK_EN enables misaligned-address
// detection (no memory access, sticky AlignError, immediate Done).
module memory_interface #(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int DATAWIDTH_MEMADDR = 12,
  parameter int WAIT_STATES       = 2
) (
  input  logic                         MEMIF_CLOCK_50,
  input  logic                         MEMIF_ResetInHigh_In,
  input  logic                         MEMIF_Read_In,
  input  logic                         MEMIF_Write_In,
  input  logic [DATAWIDTH_BUS-1:0]     MEMIF_Address_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]     MEMIF_WriteData_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]     MEMIF_MemReadData_InBUS,
  output logic [DATAWIDTH_BUS-1:0]     MEMIF_MemoryData_OutBUS,
  output logic                         MEMIF_Done_Out,
  output logic                         MEMIF_Busy_Out,
  output logic                         MEMIF_AlignError_Out,
  output logic [DATAWIDTH_MEMADDR-1:0] MEMIF_MemAddress_OutBUS,
  output logic                         MEMIF_MemRead_Out,
  output logic                         MEMIF_MemWrite_Out,
  output logic [DATAWIDTH_BUS-1:0]     MEMIF_MemWriteData_OutBUS
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Wait counter load value; WAIT_STATES is limited to 0..15.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                         state_q;
  logic [3:0]                     cnt_q;
  logic [DATAWIDTH_BUS-1:0]       data_q;
  logic [DATAWIDTH_MEMADDR-1:0]   addr_q;
  logic [DATAWIDTH_BUS-1:0]       wdata_q;
  logic                           rd_q;
  logic                           wr_q;
  logic                           done_q;
  logic                           busy_q;
  logic                           req;
  logic                           misaligned;
  logic                           unused_addr;

  assign req = MEMIF_Read_In | MEMIF_Write_In;

  // Bits outside the word field are intentionally dropped (address wraps).
  assign unused_addr = ^MEMIF_Address_InBUS;

`ifdef MEMIF_ALIGN_CHECK_EN
  logic align_q;
  assign misaligned           = |MEMIF_Address_InBUS[1:0];
  assign MEMIF_AlignError_Out = align_q;
`else
  assign misaligned           = 1'b0;
  assign MEMIF_AlignError_Out = 1'b0;
`endif

  // Access sequencer: state, wait counter, latches and all registered outputs.
  always_ff @(posedge MEMIF_CLOCK_50) begin
    if (MEMIF_ResetInHigh_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEMIF_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (req) begin
            busy_q <= 1'b1;
            if (misaligned) begin
              // Misaligned: skip the memory entirely, complete immediately.
`ifdef MEMIF_ALIGN_CHECK_EN
              align_q <= 1'b1;
`endif
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Write wins when both strobes are high.
              addr_q  <= MEMIF_Address_InBUS[DATAWIDTH_MEMADDR+1:2];
              wdata_q <= MEMIF_WriteData_InBUS;
              rd_q    <= ~MEMIF_Write_In;
              wr_q    <= MEMIF_Write_In;
              cnt_q   <= WAIT_LOAD;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Last access cycle: memory data is valid now for a read.
            if (rd_q) begin
              data_q <= MEMIF_MemReadData_InBUS;
            end
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MEMIF_MemoryData_OutBUS   = data_q;
  assign MEMIF_Done_Out            = done_q;
  assign MEMIF_Busy_Out            = busy_q;
  assign MEMIF_MemAddress_OutBUS   = addr_q;
  assign MEMIF_MemRead_Out         = rd_q;
  assign MEMIF_MemWrite_Out        = wr_q;
  assign MEMIF_MemWriteData_OutBUS = wdata_q;

endmodule

// File: tb/tb_memory_interface.sv
// Testbench for memory_interface (default parameters, WAIT_STATES=2).
// Expected read-data values are pushed to a scoreboard queue when a request
// is driven and popped when the DUT raises Done.
module tb_memory_interface;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int WS = 2;

  logic          clk;
  logic          srst;
  logic          read_i;
  logic          write_i;
  logic [DW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] memrd_i;
  logic [DW-1:0] data_o;
  logic          done_o;
  logic          busy_o;
  logic          align_o;
  logic [AW-1:0] memaddr_o;
  logic          memrd_o;
  logic          memwr_o;
  logic [DW-1:0] memwdata_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_data = '0;
  logic [DW-1:0] exp_q[$];

  memory_interface #(
    .DATAWIDTH_BUS(DW),
    .DATAWIDTH_MEMADDR(AW),
    .WAIT_STATES(WS)
  ) dut (
    .MEMIF_CLOCK_50(clk),
    .MEMIF_ResetInHigh_In(srst),
    .MEMIF_Read_In(read_i),
    .MEMIF_Write_In(write_i),
    .MEMIF_Address_InBUS(addr_i),
    .MEMIF_WriteData_InBUS(wdata_i),
    .MEMIF_MemReadData_InBUS(memrd_i),
    .MEMIF_MemoryData_OutBUS(data_o),
    .MEMIF_Done_Out(done_o),
    .MEMIF_Busy_Out(busy_o),
    .MEMIF_AlignError_Out(align_o),
    .MEMIF_MemAddress_OutBUS(memaddr_o),
    .MEMIF_MemRead_Out(memrd_o),
    .MEMIF_MemWrite_Out(memwr_o),
    .MEMIF_MemWriteData_OutBUS(memwdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle, then observe 8 cycles of the access.
  // exp_lat is the sample index (0 = just after the request edge) of Done.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] mdata, input logic extra_pulse,
                            input logic [AW-1:0] exp_addr, input int exp_lat,
                            input int exp_rd, input int exp_wr);
    int rd_cnt;
    int wr_cnt;
    int done_cnt;
    int done_at;
    logic [DW-1:0] exp_data;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    read_i = rd; write_i = wr; addr_i = addr; wdata_i = wdata; memrd_i = mdata;
    exp_data = (exp_rd > 0) ? mdata : model_data;
    exp_q.push_back(exp_data);
    model_data = exp_data;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      read_i  = (extra_pulse && i == 0) ? 1'b1 : 1'b0;
      write_i = 1'b0;
      if (i == 0) check_eq({name, ".busy"}, 32'(busy_o), 32'(1));
      if (memrd_o) rd_cnt++;
      if (memwr_o) wr_cnt++;
      if (memrd_o || memwr_o) check_eq({name, ".memaddr"}, 32'(memaddr_o), 32'(exp_addr));
      if (memwr_o) check_eq({name, ".memwdata"}, memwdata_o, wdata);
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        if (exp_q.size() == 0) begin
          check_eq({name, ".sb_empty"}, 32'(1), 32'(0));
        end else begin
          check_eq({name, ".data"}, data_o, exp_q.pop_front());
        end
      end
    end
    check_eq({name, ".done_cnt"}, 32'(done_cnt), 32'(1));
    check_eq({name, ".latency"}, 32'(done_at), 32'(exp_lat));
    check_eq({name, ".rd_cycles"}, 32'(rd_cnt), 32'(exp_rd));
    check_eq({name, ".wr_cycles"}, 32'(wr_cnt), 32'(exp_wr));
    check_eq({name, ".data_hold"}, data_o, model_data);
    $display("[TB] txn %s rd=%0b wr=%0b addr=0x%08h done_at=%0d rd_cyc=%0d wr_cyc=%0d data=0x%08h",
             name, rd, wr, addr, done_at, rd_cnt, wr_cnt, data_o);
  endtask

  initial begin
    int mis_lat;
    int mis_rd;
    int done_seen;
    srst = 1'b1; read_i = 1'b0; write_i = 1'b0;
    addr_i = '0; wdata_i = '0; memrd_i = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check_eq("rst.data", data_o, 32'h0);
    check_eq("rst.done", 32'(done_o), 32'(0));
    check_eq("rst.busy", 32'(busy_o), 32'(0));
    check_eq("rst.memaddr", 32'(memaddr_o), 32'(0));
    check_eq("rst.memrd", 32'(memrd_o), 32'(0));
    check_eq("rst.memwr", 32'(memwr_o), 32'(0));
    check_eq("rst.memwdata", memwdata_o, 32'h0);
    check_eq("rst.align", 32'(align_o), 32'(0));

    run_access("read", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 12'h004, WS+1, WS+1, 0);
    run_access("write", 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0, 1'b0, 12'h002, WS+1, 0, WS+1);
    check_eq("write.memwdata_held", memwdata_o, 32'h1234_5678);
    check_eq("write.memaddr_held", 32'(memaddr_o), 32'h002);
    run_access("rdwr", 1'b1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h1111_1111, 1'b0, 12'h008, WS+1, 0, WS+1);
    run_access("busy_req", 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hCAFE_F00D, 1'b1, 12'h003, WS+1, WS+1, 0);
    run_access("wrap", 1'b1, 1'b0, 32'h0000_4004, 32'h0, 32'h0BAD_C0DE, 1'b0, 12'h001, WS+1, WS+1, 0);

`ifdef MEMIF_ALIGN_CHECK_EN
    mis_lat = 0; mis_rd = 0;
`else
    mis_lat = WS+1; mis_rd = WS+1;
`endif
    run_access("misalign", 1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h5A5A_5A5A, 1'b0, 12'h001, mis_lat, mis_rd, 0);
`ifdef MEMIF_ALIGN_CHECK_EN
    check_eq("misalign.align", 32'(align_o), 32'(1));
`else
    check_eq("misalign.align", 32'(align_o), 32'(0));
`endif
    run_access("after_mis", 1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'h7777_8888, 1'b0, 12'h005, WS+1, WS+1, 0);
`ifdef MEMIF_ALIGN_CHECK_EN
    check_eq("after_mis.align", 32'(align_o), 32'(1));
`else
    check_eq("after_mis.align", 32'(align_o), 32'(0));
`endif

    // Reset during the second ACCESS cycle aborts the access.
    @(negedge clk);
    read_i = 1'b1; addr_i = 32'h0000_0030; memrd_i = 32'h9999_AAAA;
    @(negedge clk);
    read_i = 1'b0;
    check_eq("rstmid.memrd_before", 32'(memrd_o), 32'(1));
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check_eq("rstmid.memrd", 32'(memrd_o), 32'(0));
    check_eq("rstmid.memwr", 32'(memwr_o), 32'(0));
    check_eq("rstmid.busy", 32'(busy_o), 32'(0));
    check_eq("rstmid.done", 32'(done_o), 32'(0));
    check_eq("rstmid.data", data_o, 32'h0);
    check_eq("rstmid.memaddr", 32'(memaddr_o), 32'(0));
    check_eq("rstmid.memwdata", memwdata_o, 32'h0);
    check_eq("rstmid.align", 32'(align_o), 32'(0));
    model_data = '0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    check_eq("rstmid.no_done", 32'(done_seen), 32'(0));
    check_eq("rstmid.sb_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] txn reset_mid_access done_seen=%0d data=0x%08h", done_seen, data_o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
